mod_cache_arbiter: RTL and testbench
====================================

Name: mod_cache_arbiter

Overview:
Sits directly downstream of the L1 I-cache and L1 D-cache, on their CacheArbiterBus side. Arbitrates between the two caches for the single 64-bit system memory bus. Serializes 512-bit block writes into 8 beats and deserializes 8 read beats into one 512-bit block. Returns a single response to the granted cache.

Parameters:
BUSWIDTH, 64, system bus data width in bits
BLOCKBITS, 512, cache block width in bits
TAGWIDTH, 13, request/response tag width: [12] dir (1=READ, 0=WRITE), [11:8] type, [7:0] id
BEATS, BLOCKBITS/BUSWIDTH = 8, beats per block transfer

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_reqcyc/i_reqack  in/out  1  I-cache request valid/accept
i_req  in  64  I-cache block address
i_reqtag  in  TAGWIDTH  I-cache tag (always READ)
i_respcyc/i_respack  out/in  1  I-cache response valid/accept
i_resp  out  BLOCKBITS  I-cache response block
i_resptag  out  TAGWIDTH  I-cache response tag
d_reqcyc/d_reqack  in/out  1  D-cache request valid/accept
d_req  in  64  D-cache block address
d_reqtag  in  TAGWIDTH  D-cache tag
d_reqdata  in  BLOCKBITS  D-cache write block
d_respcyc/d_respack/d_resp/d_resptag  out/in/out/out  1/1/BLOCKBITS/TAGWIDTH  D-cache response
bus_reqcyc/bus_reqack  out/in  1  system bus request valid/accept
bus_req  out  BUSWIDTH  address beat, then data beats
bus_reqtag  out  TAGWIDTH  tag of current transfer
bus_respcyc/bus_respack  in/out  1  system bus response beat valid/accept
bus_resp  in  BUSWIDTH  response beat data
bus_resptag  in  TAGWIDTH  response beat tag

Behaviour:
- Reset (asserted low, asynchronous): state=IDLE, last_grant=I. All *cyc, *ack, data and tag outputs are 0.
- State IDLE: sample i_reqcyc and d_reqcyc.
  - One requester: grant it.
  - Both: grant the one not equal to last_grant (round-robin).
  - On grant: pulse the granted *_reqack for 1 cycle. Latch address, tag, write data and grant. Go to ADDR.
- ADDR: bus_reqcyc=1, bus_req=addr & ~63, bus_reqtag=latched tag. Hold until bus_reqack=1.
  - WRITE tag -> WDATA, beat=0.
  - READ tag -> RDATA, beat=0.
- WDATA: bus_reqcyc=1, bus_req=block[beat*64 +: 64], beat 0 first. Advance beat on each bus_reqack. On ack of beat 7 -> RESP.
- RDATA: bus_respack = bus_respcyc (combinational). Each beat stores bus_resp into block[beat*64 +: 64]. The tag is checked against the latched tag; a mismatched beat is acked but dropped. On beat 7 -> RESP.
- RESP: granted *_respcyc=1, *_resp = assembled block (writes return the written block), *_resptag = latched tag.
  - Hold until *_respack=1, then clear respcyc, set last_grant, go to IDLE.
  - Minimum latency grant->response: 1 + 1 + 8 + 1 cycles with zero-wait bus.
- The ungranted requester keeps its reqcyc high; it receives no reqack until the next IDLE cycle.
- A new request is never accepted while not in IDLE. The ungranted cache's respcyc is never asserted.
- Beat counter is 3 bits and never wraps mid-transfer. An ack on beat 7 always exits the state.
- Reset mid-transfer aborts immediately. Partial data is discarded and no response is issued.
- Simultaneous bus_reqack and i/d reqcyc: no effect outside IDLE.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_conflict_cycles[31:0].
  - Grant counters increment per grant.
  - Conflict counter increments each cycle both reqcyc are high and a client is waiting.
  - All counters are 32-bit saturating and cleared by reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package arb_pkg: TAG_DIR_BIT, TAG_READ=1, TAG_WRITE=0, BEATS, the arb_state_e enum (IDLE, ADDR, WDATA, RDATA, RESP) and the client_e enum (CLIENT_I, CLIENT_D).
- Sub-module mod_block_serdes: 512-bit block register with 3-bit beat counter. Provides load-parallel/shift-out for writes and shift-in/read-parallel for reads. Asserts a last_beat flag.

Test Plan:
- I-cache read 0x1000, bus returns beats 0..7 = 0x11*k -> single i_reqack pulse; bus_req=0x1000; i_resp word k = 0x11*k; d_respcyc never asserted.
- D-cache write 0x2040 with word k = 0xA0+k -> bus sees address 0x2040 then 8 data beats 0xA0..0xA7 in order; d_respcyc with d_resp equal to write block.
- Both request in the same cycle from reset -> D granted first (last_grant=I); I granted in the next IDLE; both complete with correct tags.
- bus_reqack held low 5 cycles during WDATA beat 3 -> bus_req stable at word 3; no beat skipped or repeated.
- Reset pulled low during RDATA beat 4 -> all outputs 0 within the same cycle; the next request completes normally.
- Read beat with mismatched bus_resptag -> beat acked and ignored; response formed only from the 8 matching beats.

Source files
------------

// File: rtl/mod_cache_arbiter_pkg.sv
// Shared types and constants for the L1 cache arbiter and its block serdes.
package arb_pkg;

    localparam int unsigned BEATS       = 8;
    localparam int unsigned BEAT_W      = 3;
    localparam int unsigned TAG_DIR_BIT = 12;

    localparam logic TAG_READ  = 1'b1;
    localparam logic TAG_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        RESP
    } arb_state_e;

    typedef enum logic {
        CLIENT_I,
        CLIENT_D
    } client_e;

endpackage

// File: rtl/mod_cache_arbiter_serdes.sv
// Block register with beat counter: parallel load / beat shift-out for writes,
// beat shift-in / parallel read for reads.
module mod_block_serdes
    import arb_pkg::*;
#(
    parameter int unsigned BUSWIDTH  = 64,
    parameter int unsigned BLOCKBITS = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [BLOCKBITS-1:0] load_data,
    input  logic                 step_out,
    input  logic                 step_in,
    input  logic [BUSWIDTH-1:0]  beat_in,
    output logic [BLOCKBITS-1:0] block,
    output logic [BUSWIDTH-1:0]  beat_out,
    output logic                 last_beat
);

    logic [BLOCKBITS-1:0] block_q, block_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;

    // Next block contents and beat index; load always restarts at beat 0.
    always_comb begin
        block_d = block_q;
        beat_d  = beat_q;
        if (load) begin
            block_d = load_data;
            beat_d  = '0;
        end else if (step_in) begin
            block_d[int'(beat_q)*BUSWIDTH +: BUSWIDTH] = beat_in;
            beat_d = beat_q + BEAT_W'(1);
        end else if (step_out) begin
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    // Block and beat registers, cleared by reset so aborted data is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_q <= '0;
            beat_q  <= '0;
        end else begin
            block_q <= block_d;
            beat_q  <= beat_d;
        end
    end

    assign block     = block_q;
    assign beat_out  = block_q[int'(beat_q)*BUSWIDTH +: BUSWIDTH];
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/mod_cache_arbiter.sv
// Round-robin arbiter between L1 I-cache and D-cache for a single 64-bit
// system bus. Serializes block writes into 8 beats, deserializes 8 read beats.
// Optional macro ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module mod_cache_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned BUSWIDTH  = 64,
    parameter int unsigned BLOCKBITS = 512,
    parameter int unsigned TAGWIDTH  = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_reqcyc,
    output logic                 i_reqack,
    input  logic [63:0]          i_req,
    input  logic [TAGWIDTH-1:0]  i_reqtag,
    output logic                 i_respcyc,
    input  logic                 i_respack,
    output logic [BLOCKBITS-1:0] i_resp,
    output logic [TAGWIDTH-1:0]  i_resptag,
    input  logic                 d_reqcyc,
    output logic                 d_reqack,
    input  logic [63:0]          d_req,
    input  logic [TAGWIDTH-1:0]  d_reqtag,
    input  logic [BLOCKBITS-1:0] d_reqdata,
    output logic                 d_respcyc,
    input  logic                 d_respack,
    output logic [BLOCKBITS-1:0] d_resp,
    output logic [TAGWIDTH-1:0]  d_resptag,
    output logic                 bus_reqcyc,
    input  logic                 bus_reqack,
    output logic [BUSWIDTH-1:0]  bus_req,
    output logic [TAGWIDTH-1:0]  bus_reqtag,
    input  logic                 bus_respcyc,
    output logic                 bus_respack,
    input  logic [BUSWIDTH-1:0]  bus_resp,
    input  logic [TAGWIDTH-1:0]  bus_resptag
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_i_grants,
    output logic [31:0]          perf_d_grants,
    output logic [31:0]          perf_conflict_cycles
`endif
);

    arb_state_e           state_q, state_d;
    client_e              grant_q, grant_d;
    client_e              last_grant_q, last_grant_d;
    client_e              pick;
    logic [63:0]          addr_q, addr_d;
    logic [TAGWIDTH-1:0]  tag_q, tag_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;

    logic                 ser_load;
    logic [BLOCKBITS-1:0] ser_load_data;
    logic                 ser_step_out;
    logic                 ser_step_in;
    logic [BLOCKBITS-1:0] ser_block;
    logic [BUSWIDTH-1:0]  ser_beat_out;
    logic                 ser_last;

    mod_block_serdes #(
        .BUSWIDTH  (BUSWIDTH),
        .BLOCKBITS (BLOCKBITS)
    ) u_serdes (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (ser_load_data),
        .step_out  (ser_step_out),
        .step_in   (ser_step_in),
        .beat_in   (bus_resp),
        .block     (ser_block),
        .beat_out  (ser_beat_out),
        .last_beat (ser_last)
    );

    // Next-state, grant selection and all bus/response outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        tag_d         = tag_q;
        i_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        pick          = CLIENT_I;
        ser_load      = 1'b0;
        ser_load_data = '0;
        ser_step_out  = 1'b0;
        ser_step_in   = 1'b0;
        bus_reqcyc    = 1'b0;
        bus_req       = '0;
        bus_reqtag    = '0;
        bus_respack   = 1'b0;
        i_respcyc     = 1'b0;
        i_resp        = '0;
        i_resptag     = '0;
        d_respcyc     = 1'b0;
        d_resp        = '0;
        d_resptag     = '0;

        case (state_q)
            IDLE: begin
                if (i_reqcyc || d_reqcyc) begin
                    if (i_reqcyc && d_reqcyc)
                        pick = (last_grant_q == CLIENT_I) ? CLIENT_D : CLIENT_I;
                    else
                        pick = d_reqcyc ? CLIENT_D : CLIENT_I;
                    grant_d  = pick;
                    state_d  = ADDR;
                    ser_load = 1'b1;
                    if (pick == CLIENT_D) begin
                        addr_d        = d_req;
                        tag_d         = d_reqtag;
                        ser_load_data = d_reqdata;
                        d_ack_d       = 1'b1;
                    end else begin
                        addr_d  = i_req;
                        tag_d   = i_reqtag;
                        i_ack_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUSWIDTH'(addr_q & ~64'h3F);
                bus_reqtag = tag_q;
                if (bus_reqack)
                    state_d = (tag_q[TAG_DIR_BIT] == TAG_READ) ? RDATA : WDATA;
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = ser_beat_out;
                bus_reqtag = tag_q;
                if (bus_reqack) begin
                    ser_step_out = 1'b1;
                    if (ser_last)
                        state_d = RESP;
                end
            end
            RDATA: begin
                bus_respack = bus_respcyc;
                // Beats carrying a foreign tag are acknowledged but not stored.
                if (bus_respcyc && (bus_resptag == tag_q)) begin
                    ser_step_in = 1'b1;
                    if (ser_last)
                        state_d = RESP;
                end
            end
            RESP: begin
                if (grant_q == CLIENT_I) begin
                    i_respcyc = 1'b1;
                    i_resp    = ser_block;
                    i_resptag = tag_q;
                    if (i_respack) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end else begin
                    d_respcyc = 1'b1;
                    d_resp    = ser_block;
                    d_resptag = tag_q;
                    if (d_respack) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= CLIENT_I;
            last_grant_q <= CLIENT_I;
            addr_q       <= '0;
            tag_q        <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign i_reqack = i_ack_q;
    assign d_reqack = d_ack_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_c_q, perf_c_d;

    // Saturating event counters for grants and contention cycles.
    always_comb begin
        perf_i_d = perf_i_q;
        perf_d_d = perf_d_q;
        perf_c_d = perf_c_q;
        if (i_ack_d && (perf_i_q != '1))
            perf_i_d = perf_i_q + 32'd1;
        if (d_ack_d && (perf_d_q != '1))
            perf_d_d = perf_d_q + 32'd1;
        if (i_reqcyc && d_reqcyc && (perf_c_q != '1))
            perf_c_d = perf_c_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_i_q <= perf_i_d;
            perf_d_q <= perf_d_d;
            perf_c_q <= perf_c_d;
        end
    end

    assign perf_i_grants        = perf_i_q;
    assign perf_d_grants        = perf_d_q;
    assign perf_conflict_cycles = perf_c_q;
`endif

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// Directed testbench for mod_cache_arbiter (default build).
module tb_mod_cache_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_reqcyc, i_reqack, i_respcyc, i_respack;
    logic [63:0]  i_req;
    logic [12:0]  i_reqtag, i_resptag;
    logic [511:0] i_resp;
    logic         d_reqcyc, d_reqack, d_respcyc, d_respack;
    logic [63:0]  d_req;
    logic [12:0]  d_reqtag, d_resptag;
    logic [511:0] d_reqdata, d_resp;
    logic         bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [63:0]  bus_req, bus_resp;
    logic [12:0]  bus_reqtag, bus_resptag;

    int checks   = 0;
    int failures = 0;
    logic [511:0] exp_blk;

    always #5 clk = ~clk;

    mod_cache_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_reqcyc    (i_reqcyc),
        .i_reqack    (i_reqack),
        .i_req       (i_req),
        .i_reqtag    (i_reqtag),
        .i_respcyc   (i_respcyc),
        .i_respack   (i_respack),
        .i_resp      (i_resp),
        .i_resptag   (i_resptag),
        .d_reqcyc    (d_reqcyc),
        .d_reqack    (d_reqack),
        .d_req       (d_req),
        .d_reqtag    (d_reqtag),
        .d_reqdata   (d_reqdata),
        .d_respcyc   (d_respcyc),
        .d_respack   (d_respack),
        .d_resp      (d_resp),
        .d_resptag   (d_resptag),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkblk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one read beat after a falling edge, check the combinational ack.
    task automatic rd_beat(input logic [63:0] data, input logic [12:0] tag);
        bus_respcyc = 1'b1;
        bus_resp    = data;
        bus_resptag = tag;
        #1;
        chk1("bus_respack", bus_respack, 1'b1);
        @(negedge clk);
        bus_respcyc = 1'b0;
    endtask

    // Block whose word k is base + mult*k.
    function automatic logic [511:0] mk_blk(input logic [63:0] base, input logic [63:0] mult);
        logic [511:0] b;
        for (int k = 0; k < 8; k++)
            b[k*64 +: 64] = base + mult * 64'(k);
        return b;
    endfunction

    initial begin
        reset = 1'b0;
        i_reqcyc = 0; i_req = '0; i_reqtag = '0; i_respack = 0;
        d_reqcyc = 0; d_req = '0; d_reqtag = '0; d_reqdata = '0; d_respack = 0;
        bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;

        // Reset state: outputs quiet even with requests pending.
        repeat (2) @(negedge clk);
        i_reqcyc = 1; d_reqcyc = 1;
        @(negedge clk);
        chk1("rst_i_reqack", i_reqack, 1'b0);
        chk1("rst_d_reqack", d_reqack, 1'b0);
        chk1("rst_bus_reqcyc", bus_reqcyc, 1'b0);
        chk64("rst_bus_req", bus_req, 64'h0);
        chk1("rst_i_respcyc", i_respcyc, 1'b0);
        chkblk("rst_d_resp", d_resp, '0);
        i_reqcyc = 0; d_reqcyc = 0;
        reset = 1'b1;
        @(negedge clk);

        // I-cache read of 0x1000, beats 0x11*k.
        i_reqcyc = 1; i_req = 64'h1000; i_reqtag = 13'h1005;
        @(negedge clk);
        chk1("t1_i_reqack", i_reqack, 1'b1);
        chk1("t1_d_reqack", d_reqack, 1'b0);
        chk1("t1_bus_reqcyc", bus_reqcyc, 1'b1);
        chk64("t1_bus_req", bus_req, 64'h1000);
        chk64("t1_bus_reqtag", 64'(bus_reqtag), 64'h1005);
        i_reqcyc = 0; bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        chk1("t1_i_reqack_pulse", i_reqack, 1'b0);
        chk1("t1_rdata_reqcyc", bus_reqcyc, 1'b0);
        for (int k = 0; k < 8; k++)
            rd_beat(64'h11 * 64'(k), 13'h1005);
        chk1("t1_i_respcyc", i_respcyc, 1'b1);
        chkblk("t1_i_resp", i_resp, mk_blk(64'h0, 64'h11));
        chk64("t1_i_resptag", 64'(i_resptag), 64'h1005);
        chk1("t1_d_respcyc", d_respcyc, 1'b0);
        i_respack = 1;
        @(negedge clk);
        i_respack = 0;
        chk1("t1_i_respcyc_clr", i_respcyc, 1'b0);

        // D-cache write of 0x2040, word k = 0xA0+k, stall on beat 3.
        exp_blk = mk_blk(64'hA0, 64'h1);
        d_reqcyc = 1; d_req = 64'h2040; d_reqtag = 13'h0233; d_reqdata = exp_blk;
        @(negedge clk);
        chk1("t2_d_reqack", d_reqack, 1'b1);
        chk1("t2_i_reqack", i_reqack, 1'b0);
        chk64("t2_bus_req_addr", bus_req, 64'h2040);
        chk64("t2_bus_reqtag", 64'(bus_reqtag), 64'h0233);
        d_reqcyc = 0;
        @(negedge clk);
        chk64("t2_addr_hold", bus_req, 64'h2040);
        bus_reqack = 1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk1("t2_wdata_reqcyc", bus_reqcyc, 1'b1);
            chk64("t2_wdata_beat", bus_req, 64'hA0 + 64'(k));
            if (k == 3) begin
                bus_reqack = 0;
                repeat (5) begin
                    @(negedge clk);
                    chk64("t2_stall_beat3", bus_req, 64'hA3);
                end
                bus_reqack = 1;
            end
            @(negedge clk);
        end
        bus_reqack = 0;
        chk1("t2_bus_reqcyc_resp", bus_reqcyc, 1'b0);
        chk1("t2_d_respcyc", d_respcyc, 1'b1);
        chkblk("t2_d_resp", d_resp, exp_blk);
        chk64("t2_d_resptag", 64'(d_resptag), 64'h0233);
        chk1("t2_i_respcyc", i_respcyc, 1'b0);
        d_respack = 1;
        @(negedge clk);
        d_respack = 0;
        chk1("t2_d_respcyc_clr", d_respcyc, 1'b0);

        // Both request from reset: D first, then I.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        i_reqcyc = 1; i_req = 64'h3000; i_reqtag = 13'h1011;
        d_reqcyc = 1; d_req = 64'h4000; d_reqtag = 13'h1122;
        @(negedge clk);
        chk1("t3_d_reqack", d_reqack, 1'b1);
        chk1("t3_i_reqack", i_reqack, 1'b0);
        chk64("t3_bus_req_d", bus_req, 64'h4000);
        chk64("t3_bus_reqtag_d", 64'(bus_reqtag), 64'h1122);
        d_reqcyc = 0; bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int k = 0; k < 8; k++)
            rd_beat(64'h100 + 64'(k), 13'h1122);
        chk1("t3_d_respcyc", d_respcyc, 1'b1);
        chkblk("t3_d_resp", d_resp, mk_blk(64'h100, 64'h1));
        chk64("t3_d_resptag", 64'(d_resptag), 64'h1122);
        chk1("t3_i_respcyc_wait", i_respcyc, 1'b0);
        chk1("t3_i_reqack_wait", i_reqack, 1'b0);
        d_respack = 1;
        @(negedge clk);
        d_respack = 0;
        chk1("t3_i_reqack_idle", i_reqack, 1'b0);
        @(negedge clk);
        chk1("t3_i_reqack", i_reqack, 1'b1);
        chk64("t3_bus_req_i", bus_req, 64'h3000);
        chk64("t3_bus_reqtag_i", 64'(bus_reqtag), 64'h1011);
        i_reqcyc = 0; bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int k = 0; k < 8; k++)
            rd_beat(64'h200 + 64'(k), 13'h1011);
        chk1("t3_i_respcyc", i_respcyc, 1'b1);
        chkblk("t3_i_resp", i_resp, mk_blk(64'h200, 64'h1));
        chk64("t3_i_resptag", 64'(i_resptag), 64'h1011);
        chk1("t3_d_respcyc_i", d_respcyc, 1'b0);
        i_respack = 1;
        @(negedge clk);
        i_respack = 0;

        // Reset asserted during read beat 4 aborts at once.
        i_reqcyc = 1; i_req = 64'h5000; i_reqtag = 13'h1077;
        @(negedge clk);
        i_reqcyc = 0; bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int k = 0; k < 4; k++)
            rd_beat(64'h400 + 64'(k), 13'h1077);
        bus_respcyc = 1; bus_resp = 64'h404; bus_resptag = 13'h1077;
        #1;
        chk1("t4_respack_pre", bus_respack, 1'b1);
        reset = 1'b0;
        #1;
        chk1("t4_rst_respack", bus_respack, 1'b0);
        chk1("t4_rst_reqcyc", bus_reqcyc, 1'b0);
        chk1("t4_rst_i_respcyc", i_respcyc, 1'b0);
        chkblk("t4_rst_i_resp", i_resp, '0);
        bus_respcyc = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk1("t4_no_resp", i_respcyc, 1'b0);

        // Next request after reset, unaligned address, one foreign-tag beat.
        i_reqcyc = 1; i_req = 64'h6025; i_reqtag = 13'h1088;
        @(negedge clk);
        chk1("t5_i_reqack", i_reqack, 1'b1);
        chk64("t5_bus_req_masked", bus_req, 64'h6000);
        i_reqcyc = 0; bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int k = 0; k < 8; k++) begin
            rd_beat(64'h500 + 64'(k), 13'h1088);
            if (k == 2)
                rd_beat(64'hDEAD, 13'h1089);
        end
        chk1("t5_i_respcyc", i_respcyc, 1'b1);
        chkblk("t5_i_resp", i_resp, mk_blk(64'h500, 64'h1));
        chk64("t5_i_resptag", 64'(i_resptag), 64'h1088);
        i_respack = 1;
        @(negedge clk);
        i_respack = 0;
        chk1("t5_i_respcyc_clr", i_respcyc, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
